// File: rtl/slow_tick_sampler_pkg.sv
// ----------------------------------------------------------------------------
// slow_tick_pkg
// Shared types and helpers for the slow tick sampler and its neighbours.
//   state_e         : read FSM states (IDLE, REQ)
//   DEFAULT_N_POINTS: default number of FFT bins scanned
//   idx_width()     : bit width of a bin index for a given bin count
//   is_pow2()       : used by the top level to reject bad N_POINTS values
// ----------------------------------------------------------------------------
package slow_tick_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int DEFAULT_N_POINTS = 64;

  // A one-bit index is still needed when only two bins exist.
  function automatic int idx_width(input int n_points);
    return (n_points > 2) ? $clog2(n_points) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/slow_tick_sampler_if.sv
// ----------------------------------------------------------------------------
// slow_tick_sampler_if
// Read port between the tick sampler (master) and the FFT output buffer
// (slave).
//   rd_req  : read request, held until acknowledged
//   rd_addr : bin index being read, stable while rd_req is high
//   rd_ack  : buffer acknowledge, rd_data valid in the same cycle
//   rd_data : sample returned by the buffer
// ----------------------------------------------------------------------------
interface slow_tick_sampler_if #(
  parameter int W_DATA = 16,
  parameter int AW     = 6
) ();

  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_ack;
  logic [W_DATA-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );

endinterface

// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain and emits a registered
// one-cycle pulse on each rising edge of it.
//   clk     : sampling clock
//   rst_n   : asynchronous reset, active-high
//   async_i : asynchronous input level
//   pulse_o : one-cycle pulse per synchronized rising edge
// ----------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   pulse_q;
  logic                   synced;

  // Bit 0 is the metastability-exposed flop; the top bit is the usable level.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= synced;
      pulse_q <= synced & ~hist_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/slow_tick_sampler.sv
// ----------------------------------------------------------------------------
// slow_tick_sampler
// Turns each rising edge of the divided slow_clk into one read of the FFT
// output buffer and holds the returned sample for the display logic.
//   clk       : fast system clock
//   rst_n     : asynchronous reset, active-high
//   slow_clk  : divided clock, treated purely as asynchronous data
//   freeze    : keeps the bin index from advancing after a read
//   rd_if     : read port to the FFT buffer (master side)
//   disp_data : last captured sample
//   disp_idx  : bin index of disp_data
//   tick      : one-cycle pulse per detected slow_clk rising edge
//   overrun   : sticky flag, a tick arrived while a read was outstanding
//   busy      : a read is outstanding
// ----------------------------------------------------------------------------
module slow_tick_sampler
  import slow_tick_pkg::*;
#(
  parameter int W_DATA      = 16,
  parameter int N_POINTS    = DEFAULT_N_POINTS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           slow_clk,
  input  logic                           freeze,
  slow_tick_sampler_if.master            rd_if,
  output logic [W_DATA-1:0]              disp_data,
  output logic [idx_width(N_POINTS)-1:0] disp_idx,
  output logic                           tick,
  output logic                           overrun,
  output logic                           busy
);

  localparam int  AW         = idx_width(N_POINTS);
  localparam bit  N_POW2_OK  = is_pow2(N_POINTS);
  localparam bit  SYNC_OK    = (SYNC_STAGES >= 2);

  // The index counter relies on natural binary wrap, so a non power of two
  // bin count would scan phantom bins.
  generate
    if (!N_POW2_OK) begin : g_bad_n_points
      $error("slow_tick_sampler: N_POINTS must be a power of two >= 2");
    end
    if (!SYNC_OK) begin : g_bad_sync
      $error("slow_tick_sampler: SYNC_STAGES must be >= 2");
    end
  endgenerate

  state_e            state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [W_DATA-1:0] disp_data_q, disp_data_d;
  logic [AW-1:0]     disp_idx_q, disp_idx_d;
  logic              overrun_q, overrun_d;
  logic              tick_w;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (slow_clk),
    .pulse_o (tick_w)
  );

  // A tick while REQ, including the ack cycle, is dropped: the capture in that
  // cycle belongs to the older tick and the new one has no slot to start in.
  always_comb begin
    state_d     = state_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    idx_d       = idx_q;
    disp_data_d = disp_data_q;
    disp_idx_d  = disp_idx_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (tick_w) begin
          state_d   = REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = idx_q;
        end
      end
      REQ: begin
        if (tick_w) begin
          overrun_d = 1'b1;
        end
        if (rd_if.rd_ack) begin
          state_d     = IDLE;
          rd_req_d    = 1'b0;
          disp_data_d = rd_if.rd_data;
          disp_idx_d  = rd_addr_q;
          if (!freeze) begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // Reset also abandons an outstanding read, dropping rd_req immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      idx_q       <= '0;
      disp_data_q <= '0;
      disp_idx_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      idx_q       <= idx_d;
      disp_data_q <= disp_data_d;
      disp_idx_q  <= disp_idx_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rd_if.rd_req  = rd_req_q;
  assign rd_if.rd_addr = rd_addr_q;
  assign disp_data     = disp_data_q;
  assign disp_idx      = disp_idx_q;
  assign tick          = tick_w;
  assign overrun       = overrun_q;
  assign busy          = (state_q == REQ);

endmodule

// File: tb/tb_slow_tick_sampler.sv
// ----------------------------------------------------------------------------
// tb_slow_tick_sampler
// Drives slow_clk pulses into slow_tick_sampler while a responder plays the
// FFT buffer. The responder keeps a model of which bin should be read next
// and what the display should show, and checks every read against it.
// ----------------------------------------------------------------------------
module tb_slow_tick_sampler;

  localparam int W    = 16;
  localparam int N    = 16;
  localparam int AW   = 4;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          slow_clk = 1'b0;
  logic          freeze = 1'b0;
  logic [W-1:0]  disp_data;
  logic [AW-1:0] disp_idx;
  logic          tick;
  logic          overrun;
  logic          busy;

  slow_tick_sampler_if #(.W_DATA(W), .AW(AW)) rdIf ();

  slow_tick_sampler #(
    .W_DATA      (W),
    .N_POINTS    (N),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .slow_clk  (slow_clk),
    .freeze    (freeze),
    .rd_if     (rdIf.master),
    .disp_data (disp_data),
    .disp_idx  (disp_idx),
    .tick      (tick),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Buffer contents and behavioural model, owned by the responder.
  logic [W-1:0] bufMem [N];
  int           expIdx = 0;
  int           readsDone = 0;
  logic [W-1:0] modelDispData = '0;
  int           modelDispIdx = 0;

  // Responder controls, owned by the main sequence.
  bit ackEnable = 1'b1;
  int ackDelay = 0;
  int spuriousReq = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Emits n slow_clk periods with half period h clk cycles, starting high.
  task automatic applyStimulus(input int n, input int h);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1;
      repeat (h) @(negedge clk);
      slow_clk = 1'b0;
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic waitReads(input int target, input int budget);
    int cnt = 0;
    while (readsDone < target && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("readsDone", readsDone, target);
  endtask

  // Buffer responder: acks rd_req after ackDelay cycles, checks the address
  // against the model and checks the display one edge after each ack.
  initial begin : responder
    int           waitCnt = 0;
    bit           pending = 1'b0;
    bit           spuriousActive = 1'b0;
    bit           ackFreeze = 1'b0;
    int           ackAddr = 0;
    int           spuriousDone = 0;
    rdIf.rd_ack  = 1'b0;
    rdIf.rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        rdIf.rd_ack    = 1'b0;
        waitCnt        = 0;
        pending        = 1'b0;
        spuriousActive = 1'b0;
        expIdx         = 0;
        modelDispData  = '0;
        modelDispIdx   = 0;
      end else if (rdIf.rd_ack) begin
        rdIf.rd_ack = 1'b0;
        if (spuriousActive) begin
          spuriousActive = 1'b0;
        end else begin
          modelDispData = bufMem[ackAddr];
          modelDispIdx  = ackAddr;
          checkOutput("dispData", disp_data, modelDispData);
          checkOutput("dispIdx", disp_idx, modelDispIdx);
          checkOutput("reqDropped", rdIf.rd_req, 0);
          if (!ackFreeze) expIdx = (expIdx + 1) % N;
          readsDone++;
          pending = 1'b0;
        end
      end else if (spuriousReq != spuriousDone && !rdIf.rd_req) begin
        rdIf.rd_ack    = 1'b1;
        rdIf.rd_data   = W'($urandom);
        spuriousDone++;
        spuriousActive = 1'b1;
      end else if (rdIf.rd_req) begin
        pending = 1'b1;
        checkOutput("rdAddr", rdIf.rd_addr, expIdx);
        if (ackEnable && waitCnt >= ackDelay) begin
          rdIf.rd_ack  = 1'b1;
          rdIf.rd_data = bufMem[rdIf.rd_addr];
          ackAddr      = int'(rdIf.rd_addr);
          ackFreeze    = freeze;
          waitCnt      = 0;
        end else begin
          waitCnt++;
        end
      end else if (pending) begin
        checkOutput("reqHeld", rdIf.rd_req, 1);
        pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    checkOutput("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : mainSeq
    int startReads;
    for (int i = 0; i < N; i++) bufMem[i] = W'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstReq", rdIf.rd_req, 0);
    checkOutput("rstAddr", rdIf.rd_addr, 0);
    checkOutput("rstDispData", disp_data, 0);
    checkOutput("rstDispIdx", disp_idx, 0);
    checkOutput("rstTick", tick, 0);
    checkOutput("rstOverrun", overrun, 0);
    checkOutput("rstBusy", busy, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Immediate ack, one read per slow_clk period
    ackDelay = 0;
    applyStimulus(5, 20);
    waitReads(5, 100);
    checkOutput("basicIdx", disp_idx, 4);
    checkOutput("basicOverrun", overrun, 0);

    // Delayed ack: address held while waiting
    ackDelay = 5;
    applyStimulus(2, 20);
    waitReads(7, 100);
    checkOutput("delayIdx", disp_idx, 6);

    // Freeze at index 7
    freeze = 1'b1;
    applyStimulus(3, 20);
    waitReads(10, 100);
    checkOutput("freezeIdx", disp_idx, 7);
    freeze = 1'b0;
    applyStimulus(2, 20);
    waitReads(12, 100);
    checkOutput("unfreezeIdx", disp_idx, 8);

    // Randomized periods, ack delays and freeze, sized so no tick is dropped
    startReads = readsDone;
    for (int i = 0; i < 30; i++) begin
      int h;
      h        = int'($urandom_range(5, 12));
      ackDelay = int'($urandom_range(0, 2 * h - 6));
      freeze   = ($urandom_range(0, 3) == 0);
      applyStimulus(1, h);
    end
    waitReads(startReads + 30, 100);
    freeze = 1'b0;
    checkOutput("randOverrun", overrun, 0);

    // Ack while idle must not disturb the display
    spuriousReq++;
    repeat (4) @(negedge clk);
    checkOutput("idleAckData", disp_data, modelDispData);
    checkOutput("idleAckIdx", disp_idx, modelDispIdx);
    checkOutput("idleAckBusy", busy, 0);

    // Ack withheld across several ticks: overrun, only one advance
    ackDelay   = 0;
    ackEnable  = 1'b0;
    startReads = readsDone;
    applyStimulus(3, 20);
    checkOutput("withheldBusy", busy, 1);
    checkOutput("withheldOverrun", overrun, 1);
    ackEnable = 1'b1;
    waitReads(startReads + 1, 20);
    applyStimulus(2, 20);
    waitReads(startReads + 3, 100);
    checkOutput("stickyOverrun", overrun, 1);

    // Reset in the middle of a read, then a late ack
    ackEnable = 1'b0;
    slow_clk  = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("preRstReq", rdIf.rd_req, 1);
    rst_n = 1'b1;
    #1;
    checkOutput("asyncRstReq", rdIf.rd_req, 0);
    checkOutput("asyncRstBusy", busy, 0);
    slow_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    spuriousReq++;
    repeat (4) @(negedge clk);
    checkOutput("lateAckData", disp_data, 0);
    checkOutput("lateAckIdx", disp_idx, 0);
    checkOutput("lateAckReq", rdIf.rd_req, 0);
    checkOutput("postRstOverrun", overrun, 0);
    ackEnable  = 1'b1;
    startReads = readsDone;
    applyStimulus(1, 20);
    waitReads(startReads + 1, 50);
    checkOutput("postRstIdx", disp_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
